// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit with valid/ready handshakes on both sides.
// Fixed latency: one accept edge, DATA_WIDTH iteration edges, one fix-up edge.
module mdu_iter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ARGS_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ARGS_WIDTH-1:0] i_type,
  input  logic [DATA_WIDTH-1:0] i_rs1_data,
  input  logic [DATA_WIDTH-1:0] i_rs2_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_res,
  output logic                  o_busy
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned W2 = 2 * DATA_WIDTH;

  localparam logic [ARGS_WIDTH-1:0] TypeFirst = ARGS_WIDTH'(18);
  localparam logic [ARGS_WIDTH-1:0] TypeLast  = ARGS_WIDTH'(25);
  localparam logic [W-1:0]          LastIter  = W'(W - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFin, StDone} state_e;

  // Ordered so that bit 2 selects divide and bit 1 (within divide) selects remainder.
  typedef enum logic [2:0] {
    OpMul, OpMulh, OpMulhsu, OpMulhu, OpDiv, OpDivu, OpRem, OpRemu
  } op_e;

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic            op_ok_q, op_ok_d;
  logic            sign1_q, sign1_d;
  logic            sign2_q, sign2_d;
  logic            zero_q, zero_d;
  logic [W-1:0]    opnd_q, opnd_d;
  logic [W2-1:0]   acc_q, acc_d;
  logic [W-1:0]    cnt_q, cnt_d;
  logic [W-1:0]    res_q, res_d;

  // Request decode
  logic            type_ok;
  op_e             op_in;
  logic            rs1_signed, rs2_signed;
  logic            sgn1_in, sgn2_in;
  logic [W-1:0]    mag1_in, mag2_in;

  always_comb begin
    type_ok    = (i_type >= TypeFirst) && (i_type <= TypeLast);
    op_in      = op_e'(3'(i_type[2:0] - 3'd2));
    rs1_signed = (op_in == OpMul) || (op_in == OpMulh) || (op_in == OpMulhsu) ||
                 (op_in == OpDiv) || (op_in == OpRem);
    rs2_signed = (op_in == OpMul) || (op_in == OpMulh) || (op_in == OpDiv) || (op_in == OpRem);
    sgn1_in    = rs1_signed && i_rs1_data[W-1];
    sgn2_in    = rs2_signed && i_rs2_data[W-1];
    mag1_in    = sgn1_in ? (-i_rs1_data) : i_rs1_data;
    mag2_in    = sgn2_in ? (-i_rs2_data) : i_rs2_data;
  end

  // One iteration step of each datapath
  logic [W:0]      mul_add;
  logic [W2-1:0]   mul_next;
  logic [W:0]      rem_sh;
  logic [W:0]      trial;
  logic [W2-1:0]   div_next;

  always_comb begin
    // Multiply: acc = {partial high, remaining multiplier bits}, shifted right each step.
    mul_add  = {1'b0, acc_q[W2-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W + 1){1'b0}});
    mul_next = {mul_add, acc_q[W-1:1]};
    // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left each step.
    rem_sh   = {acc_q[W2-1:W], acc_q[W-1]};
    trial    = rem_sh - {1'b0, opnd_q};
    if (!trial[W]) begin
      div_next = {trial[W-1:0], acc_q[W-2:0], 1'b1};
    end else begin
      div_next = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
    end
  end

  // Sign fix-up and special cases
  logic [W2-1:0]   prod_fix;
  logic [W-1:0]    quo, rem, quo_fix, rem_fix;
  logic [W-1:0]    fin_res;

  always_comb begin
    prod_fix = (sign1_q ^ sign2_q) ? (-acc_q) : acc_q;
    quo      = acc_q[W-1:0];
    rem      = acc_q[W2-1:W];
    quo_fix  = (sign1_q ^ sign2_q) ? (-quo) : quo;
    // Divide-by-zero leaves |rs1| in the remainder, so the dividend sign restores rs1.
    rem_fix  = sign1_q ? (-rem) : rem;
    fin_res  = '0;
    unique case (op_q)
      OpMul:                   fin_res = prod_fix[W-1:0];
      OpMulh, OpMulhsu, OpMulhu: fin_res = prod_fix[W2-1:W];
      OpDiv, OpDivu:           fin_res = zero_q ? {W{1'b1}} : quo_fix;
      OpRem, OpRemu:           fin_res = rem_fix;
      default:                 fin_res = '0;
    endcase
    if (!op_ok_q) begin
      fin_res = '0;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    op_ok_d = op_ok_q;
    sign1_d = sign1_q;
    sign2_d = sign2_q;
    zero_d  = zero_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;

    if (i_flush && (state_q != StIdle)) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_valid && !i_flush) begin
            state_d = StCalc;
            op_d    = op_in;
            op_ok_d = type_ok;
            sign1_d = sgn1_in;
            sign2_d = sgn2_in;
            zero_d  = (i_rs2_data == '0);
            cnt_d   = '0;
            if (op_in[2]) begin
              opnd_d = mag2_in;
              acc_d  = {{W{1'b0}}, mag1_in};
            end else begin
              opnd_d = mag1_in;
              acc_d  = {{W{1'b0}}, mag2_in};
            end
          end
        end
        StCalc: begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastIter) begin
            state_d = StFin;
          end
        end
        StFin: begin
          res_d   = fin_res;
          state_d = StDone;
        end
        StDone: begin
          if (i_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      op_q    <= OpMul;
      op_ok_q <= 1'b0;
      sign1_q <= 1'b0;
      sign2_q <= 1'b0;
      zero_q  <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      op_ok_q <= op_ok_d;
      sign1_q <= sign1_d;
      sign2_q <= sign2_d;
      zero_q  <= zero_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    o_ready = (state_q == StIdle);
    o_valid = (state_q == StDone);
    o_busy  = (state_q != StIdle);
    o_res   = res_q;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit executing the RV32M type codes (`ALU_TYPE_MUL` 18 through `ALU_TYPE_REMU` 25). The combinational ALU decodes these codes but produces 0 for them.
- Sits beside the ALU in the execute stage and uses the same type encoding and operand ports.
- Adds a valid/ready request/response handshake so the pipeline can stall on its fixed multi-cycle latency.

Parameters:
- DATA_WIDTH, 32, operand/result width (32 or 64).
- ARGS_WIDTH, 10, width of i_type (same encoding as the ALU).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_flush  in  1  abort the in-flight operation (pipeline flush).
- i_valid  in  1  request valid.
- o_ready  out  1  unit can accept a request (high only in IDLE).
- i_type  in  ARGS_WIDTH  operation code, 18..25.
- i_rs1_data  in  DATA_WIDTH  operand 1 (dividend / multiplicand).
- i_rs2_data  in  DATA_WIDTH  operand 2 (divisor / multiplier).
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_res  out  DATA_WIDTH  result.
- o_busy  out  1  high in CALC, FIN or DONE.

Behaviour:
- Reset: one clock i_clk; reset is asynchronous and active-low (i_rst_n). While i_rst_n is low:
  - state = IDLE;
  - o_valid = 0, o_res = 0, o_busy = 0;
  - o_ready = 1 once i_rst_n is high.
  - Reset mid-operation discards all state; no result is produced.
- States: IDLE, CALC, FIN, DONE.
- IDLE -> CALC on an edge with i_valid & o_ready (the accept edge E0). At E0:
  - latch op, operand signs and operand magnitudes;
  - magnitudes use two's-complement negation for signed operands;
  - MULHSU treats rs1 as signed and rs2 as unsigned; MULHU, DIVU and REMU treat both as unsigned.
- CALC: one iteration per edge E1..E_N, N = DATA_WIDTH. A DATA_WIDTH-wide counter sets the iteration count.
  - Multiply: radix-2 shift-add into a 2*DATA_WIDTH accumulator.
  - Divide: restoring shift-subtract, giving quotient and remainder.
  - After E_N the state goes to FIN.
- FIN: one cycle at E_{N+1}. Applies the sign fix and special cases, registers o_res, then goes to DONE.
  - MUL: low half of the signed product (identical for all signs).
  - MULH / MULHSU: high half; negate the full 2*DATA_WIDTH product if sign1^sign2 (MULHSU: sign2 = 0).
  - MULHU: high half of the unsigned product.
  - DIV: quotient negated if s1^s2. REM: remainder takes the sign of the dividend.
  - Divide by zero:
    - DIV/DIVU -> all ones;
    - REM/REMU -> original rs1.
  - Signed overflow (rs1 = most-negative, rs2 = -1):
    - DIV -> most-negative;
    - REM -> 0.
  - Special cases run the full fixed latency; there is no early exit.
  - i_type outside 18..25: accepted, o_res = 0, same latency.
- DONE: o_valid = 1.
  - o_res and o_valid hold stable until i_ready = 1.
  - On the handshake edge the state returns to IDLE and o_valid drops.
  - No new request is accepted in that same cycle (o_ready is low in DONE).
- Latency: o_valid is first high in the cycle after E_{N+1}, i.e. N+1 edges after acceptance (33 for DATA_WIDTH = 32). Throughput is one operation per N+3 cycles minimum.
- i_flush:
  - High at any edge in CALC, FIN or DONE -> IDLE; o_valid = 0 on the next cycle; the result is dropped.
  - In IDLE it blocks acceptance: o_ready stays high but the request is ignored.
  - Flush has priority over all other transitions.
- Operands and i_type are sampled only at E0; later changes have no effect.
- o_res keeps its last value after the DONE handshake, until overwritten at the next FIN.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3) -> o_res = 0xFFFFFFEB, o_valid exactly 33 edges after accept.
- High-half multiplies:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000;
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE;
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide and remainder:
  - DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD;
  - REM -7 % 2 -> 0xFFFFFFFF;
  - DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
- Special cases:
  - DIV 5 / 0 -> 0xFFFFFFFF;
  - REMU 5 / 0 -> 5;
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000;
  - REM of the same operands -> 0.
- Backpressure: hold i_ready low 5 cycles after o_valid -> o_res and o_valid stable, o_ready = 0 throughout, and a back-to-back request is accepted only after return to IDLE.
- Abort paths:
  - Assert i_flush at iteration 10 -> o_valid never rises, o_ready = 1 next cycle.
  - Repeat with i_rst_n pulsed low mid-CALC -> all outputs immediately at reset values.
